// File: rtl/tff_universal_reg.sv
// Universal flip-flop register: every bit is a T flip-flop (q <= q ^ t).
// D / T / JK / SR inputs are turned into a per-bit toggle vector t.
// Optional counter modes under macro TFF_UNIVERSAL_REG_COUNT_EN.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset (q=RESET_VAL, flags cleared)
//   en       update enable, 0 holds every bit
//   mode     000 D, 001 T, 010 JK, 011 SR, 100 up, 101 down, 11x hold
//   a        d / t / j / s operand
//   b        k / r operand (unused in D and T modes)
//   q, qn    register state and its complement
//   changed  one-cycle pulse after q changed value
//   sr_err   sticky SR set+reset conflict flag
//   wrap     one-cycle pulse after a counter wrap (0 without the macro)
module tff_universal_reg #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             changed,
    output logic             sr_err,
    output logic             wrap
);

    localparam logic [2:0] MODE_D  = 3'b000;
    localparam logic [2:0] MODE_T  = 3'b001;
    localparam logic [2:0] MODE_JK = 3'b010;
    localparam logic [2:0] MODE_SR = 3'b011;
`ifdef TFF_UNIVERSAL_REG_COUNT_EN
    localparam logic [2:0] MODE_UP = 3'b100;
    localparam logic [2:0] MODE_DN = 3'b101;
`endif

    logic [WIDTH-1:0] r_q;
    logic             r_changed;
    logic             r_sr_err;
    logic             r_wrap;

    logic [WIDTH-1:0] w_t;
    logic             w_sr_conf;
    logic             w_wrap;

`ifdef TFF_UNIVERSAL_REG_COUNT_EN
    // Bit i toggles when all lower bits are 1 (up) or all are 0 (down).
    logic [WIDTH-1:0] w_up;
    logic [WIDTH-1:0] w_dn;

    always_comb begin : cnt_chain
        logic c_up;
        logic c_dn;
        c_up = 1'b1;
        c_dn = 1'b1;
        w_up = '0;
        w_dn = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_up[i] = c_up;
            w_dn[i] = c_dn;
            c_up    = c_up & r_q[i];
            c_dn    = c_dn & ~r_q[i];
        end
    end
`endif

    always_comb begin
        w_t = '0;
        if (en) begin
            case (mode)
                MODE_D:  w_t = a ^ r_q;
                MODE_T:  w_t = a;
                MODE_JK: w_t = (a & ~r_q) | (b & r_q);
                // s=r=1 on a bit leaves that bit alone
                MODE_SR: w_t = (a & ~b & ~r_q) | (b & ~a & r_q);
`ifdef TFF_UNIVERSAL_REG_COUNT_EN
                MODE_UP: w_t = w_up;
                MODE_DN: w_t = w_dn;
`endif
                default: w_t = '0;
            endcase
        end
    end

    assign w_sr_conf = en && (mode == MODE_SR) && (|(a & b));

`ifdef TFF_UNIVERSAL_REG_COUNT_EN
    assign w_wrap = en && (((mode == MODE_UP) && (&r_q)) ||
                           ((mode == MODE_DN) && ~(|r_q)));
`else
    assign w_wrap = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q       <= RESET_VAL;
            r_changed <= 1'b0;
            r_sr_err  <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_q       <= r_q ^ w_t;
            r_changed <= |w_t;
            r_wrap    <= w_wrap;
            if (w_sr_conf) begin
                r_sr_err <= 1'b1;
            end
        end
    end

    assign q       = r_q;
    assign qn      = ~r_q;
    assign changed = r_changed;
    assign sr_err  = r_sr_err;
    assign wrap    = r_wrap;

endmodule
